// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage enabled register pipeline with valid bits and tap read.
// Optional macro REG_PIPE_OCCUPANCY_EN adds the registered CNT occupancy port.
module reg_pipe #(
   parameter int           W       = 8,
   parameter int           DEPTH   = 4,
   parameter logic [W-1:0] RST_VAL = '0,
   localparam int          TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          EN,
   input  logic          FLUSH,
   input  logic [W-1:0]  D,
   input  logic          DV,
   output logic [W-1:0]  Q,
   output logic          QV,
   input  logic [TW-1:0] TAP_SEL,
   output logic [W-1:0]  TAP_Q,
   output logic          TAP_V
`ifdef REG_PIPE_OCCUPANCY_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] CNT
`endif
);

   logic [W-1:0]     r_s [DEPTH];
   logic [DEPTH-1:0] r_v;

   // Data stages: shift on EN, untouched by FLUSH so data stays deterministic.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < DEPTH; k++) r_s[k] <= RST_VAL;
      end else if (EN) begin
         r_s[0] <= D;
         for (int k = 1; k < DEPTH; k++) r_s[k] <= r_s[k-1];
      end
   end

   // Valid stages: FLUSH wipes every valid bit, otherwise shift alongside data.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_v <= '0;
      end else if (FLUSH) begin
         r_v <= '0;
      end else if (EN) begin
         r_v[0] <= DV;
         for (int k = 1; k < DEPTH; k++) r_v[k] <= r_v[k-1];
      end
   end

   assign Q  = r_s[DEPTH-1];
   assign QV = r_v[DEPTH-1];

   // Tap mux; indices past the last stage read as reset data, invalid.
   always_comb begin
      TAP_Q = RST_VAL;
      TAP_V = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (TAP_SEL == TW'(k)) begin
            TAP_Q = r_s[k];
            TAP_V = r_v[k];
         end
      end
   end

`ifdef REG_PIPE_OCCUPANCY_EN
   localparam int CW = $clog2(DEPTH+1);

   logic [CW-1:0] r_cnt;

   // Occupancy tracks the number of set valid bits: +1 entering, -1 leaving.
   always_ff @(posedge CLK) begin
      if (RST || FLUSH) begin
         r_cnt <= '0;
      end else if (EN) begin
         r_cnt <= r_cnt + CW'(DV) - CW'(r_v[DEPTH-1]);
      end
   end

   assign CNT = r_cnt;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: randomized scoreboard bench for reg_pipe (W=8, DEPTH=3).
// Model tracks each accepted word and how many enabled edges it still needs.
module tb_reg_pipe;

   localparam int         W     = 8;
   localparam int         DEPTH = 3;
   localparam logic [7:0] RV    = 8'h5A;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       EN = 1'b0;
   logic       FLUSH = 1'b0;
   logic [7:0] D = '0;
   logic       DV = 1'b0;
   logic [7:0] Q;
   logic       QV;
   logic [1:0] TAP_SEL = '0;
   logic [7:0] TAP_Q;
   logic       TAP_V;
`ifdef REG_PIPE_OCCUPANCY_EN
   logic [1:0] CNT;
`endif

   reg_pipe #(.W(W), .DEPTH(DEPTH), .RST_VAL(RV)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .FLUSH(FLUSH),
      .D(D), .DV(DV), .Q(Q), .QV(QV),
      .TAP_SEL(TAP_SEL), .TAP_Q(TAP_Q), .TAP_V(TAP_V)
`ifdef REG_PIPE_OCCUPANCY_EN
      , .CNT(CNT)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] d;
      int         rem;
   } ent_t;

   ent_t       infl[$];
   logic [7:0] expq[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         mon_on = 1'b0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model is advanced for the coming edge.
   task automatic step(input logic rst, input logic en, input logic fl,
                       input logic dv, input logic [7:0] d,
                       input logic [1:0] ts);
      @(negedge CLK);
      RST = rst; EN = en; FLUSH = fl; DV = dv; D = d; TAP_SEL = ts;
      mon_on = 1'b1;
      if (rst || fl) begin
         infl.delete();
      end else if (en) begin
         if (infl.size() > 0 && infl[0].rem == 0) void'(infl.pop_front());
         foreach (infl[i]) begin
            infl[i].rem--;
            if (infl[i].rem == 0) expq.push_back(infl[i].d);
         end
         if (dv) begin
            ent_t e;
            e.d = d;
            e.rem = DEPTH - 1;
            infl.push_back(e);
            if (e.rem == 0) expq.push_back(d);
         end
      end
   endtask

   // Monitor: pops the scoreboard whenever a new word is presented on Q.
   initial begin
      logic       en_s, rst_s, fl_s, exp_tv;
      logic [7:0] prev_q, exp_tq;
      int         pos;
      forever begin
         @(posedge CLK);
         en_s = EN; rst_s = RST; fl_s = FLUSH;
         #1;
         if (mon_on) begin
            check("qv", 32'(QV),
                  32'(infl.size() > 0 && infl[0].rem == 0));
            if (rst_s) begin
               check("rst_q", 32'(Q), 32'(RV));
            end else if (!en_s) begin
               check("hold_q", 32'(Q), 32'(prev_q));
            end
            if (!rst_s && !fl_s && en_s && QV) begin
               if (expq.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL pop_empty: got %0h expected none", Q);
               end else begin
                  check("q", 32'(Q), 32'(expq.pop_front()));
               end
            end
            exp_tv = 1'b0;
            exp_tq = RV;
            foreach (infl[i]) begin
               pos = DEPTH - 1 - infl[i].rem;
               if (pos == int'(TAP_SEL)) begin
                  exp_tv = 1'b1;
                  exp_tq = infl[i].d;
               end
            end
            check("tap_v", 32'(TAP_V), 32'(exp_tv));
            if (exp_tv || int'(TAP_SEL) >= DEPTH || rst_s)
               check("tap_q", 32'(TAP_Q), 32'(exp_tq));
`ifdef REG_PIPE_OCCUPANCY_EN
            check("cnt", 32'(CNT), 32'(infl.size()));
`endif
         end
         prev_q = Q;
      end
   end

   initial begin
      logic [7:0] seq [5];
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
      seq[3] = 8'h44; seq[4] = 8'h55;
      step(1, 0, 0, 0, 8'h00, 2'd0);
      step(1, 1, 1, 1, 8'hFF, 2'd3);
      // Back-to-back stream.
      for (int i = 0; i < 5; i++) step(0, 1, 0, 1, seq[i], 2'(i % 4));
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 8'h00, 2'd2);
      // Stall while a word is in flight.
      step(0, 1, 0, 1, 8'hA5, 2'd0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'hEE, 2'(i));
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 8'h00, 2'd2);
      // Flush a full pipe, then refill.
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, 8'(8'h60 + i), 2'd1);
      step(0, 1, 1, 1, 8'h77, 2'd0);
      step(0, 1, 0, 1, 8'h88, 2'd0);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 8'h00, 2'd0);
      // Reset mid-stream with EN and FLUSH also high.
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, 8'(8'h90 + i), 2'd2);
      step(1, 1, 1, 1, 8'h99, 2'd1);
      for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 0, 0, 8'h00, 2'd3);
      // Tap readout after loading 01,02,03.
      for (int i = 1; i <= 3; i++) step(0, 1, 0, 1, 8'(i), 2'd0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 8'h00, 2'(i));
      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6,
              8'($urandom), 2'($urandom_range(0, 3)));
      end
      for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 0, 0, 8'h00, 2'd0);
      @(negedge CLK);
      check("drain", 32'(expq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
